spi_rx_controller: RTL and testbench
====================================

SPI_RX_CONTROLLER -- requirements
Module: spi_rx_controller

Interface
REQ-001 The block SHALL have parameter: size, 25, frame width in bits delivered to the router.
REQ-002 The block SHALL have parameter: SYNC_STAGES, 2, synchronizer depth for masterClock, bitInMaster and selector.
REQ-003 The block SHALL have port: clock  input  1  FPGA system clock; only clock in the block.
REQ-004 The block SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port: clear  input  1  synchronous clear, active-high, same effect as reset.
REQ-006 The block SHALL have port: masterClock  input  1  SPI SCK from master, asynchronous to clock.
REQ-007 The block SHALL have port: bitInMaster  input  1  SPI MOSI, sampled on SCK rising edge.
REQ-008 The block SHALL have port: selector  input  1  chip select, active-high, frames a transfer.
REQ-009 The block SHALL have port: frameReady  input  1  router accepts the frame this cycle.
REQ-010 The block SHALL have port: frameValid  output  1  dataOut holds an unconsumed frame.
REQ-011 The block SHALL have port: dataOut  output  size  received frame, first bit received in MSB.
REQ-012 The block SHALL have port: overrun  output  1  sticky: a completed frame was dropped.
REQ-013 The block SHALL have port: abortPulse  output  1  one-cycle pulse: selector fell mid-frame.

Function
REQ-014 The block SHALL synchronize masterClock, bitInMaster, selector through SYNC_STAGES flops each, then register synchronized SCK once more for edge detection.
REQ-015 The block SHALL recognise an SCK rising edge as synchronized SCK = 1 and its delayed copy = 0.
REQ-016 The FSM SHALL have states IDLE, RECEIVE, DONE; reset state IDLE.
REQ-017 IDLE -> RECEIVE when synchronized selector = 1; bit counter cleared to 0 on entry.
REQ-018 In RECEIVE, each SCK rising edge SHALL shift the synchronized MOSI bit into the LSB of the shift register and increment the bit counter (width clog2(size+1)).
REQ-019 When the counter reaches size, the FSM SHALL enter DONE and copy the shift register to the output buffer on the next clock.
REQ-020 In DONE, further SCK edges SHALL be ignored; DONE -> IDLE when synchronized selector = 0.
REQ-021 Selector low in RECEIVE with counter < size SHALL return to IDLE, discard partial bits, and pulse abortPulse for exactly one cycle.
REQ-022 Transfer SHALL complete when frameValid = 1 and frameReady = 1; frameValid SHALL deassert the following cycle unless a new frame loads that same cycle.
REQ-023 A frame completing while frameValid = 1 and frameReady = 0 SHALL be dropped, leave dataOut unchanged, and set overrun.
REQ-024 A frame completing in the same cycle as a transfer SHALL be loaded with frameValid held at 1, without setting overrun.
REQ-025 dataOut SHALL be stable while frameValid = 1 and frameReady = 0.
REQ-026 overrun SHALL clear only on reset or clear.

Reset
REQ-027 Reset low or clear high SHALL force: state IDLE, counter 0, shift register 0, dataOut 0, frameValid 0, overrun 0, abortPulse 0, synchronizer flops 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without pulsing abortPulse; reception restarts on the next selector-high after release.

Configuration
REQ-029 With macro SPI_RX_PARITY_EN defined, each frame SHALL carry size+1 bits, the last being even parity over the preceding size bits.
REQ-030 With SPI_RX_PARITY_EN, a parity mismatch SHALL discard the frame, not load or set frameValid, and pulse output parityError for one cycle.
REQ-031 Without SPI_RX_PARITY_EN, frames SHALL be exactly size bits and port parityError SHALL not exist.

Structure
REQ-032 FSM state encodings (IDLE=0, RECEIVE=1, DONE=2) and default frame width 25 SHALL live in the shared package spi_router_pkg.
REQ-033 Synchronizer plus edge detector SHALL be one sub-module, spi_edge_sync, instantiated once for SCK and reused (no edge output) for MOSI and selector.

Verification
REQ-034 Selector high, 25 SCK cycles (SCK period 8 clocks) sending 0x1A5A5A5 -> frameValid=1, dataOut=0x1A5A5A5; SCK-edge-to-frameValid latency is SYNC_STAGES+3 clocks.
REQ-035 Frame 0x0000001 held with frameReady=0, second frame 0x1FFFFFF completes -> dataOut stays 0x0000001, overrun=1.
REQ-036 Selector dropped after 10 bits -> abortPulse one cycle, frameValid stays 0, next full frame 0x0ABCDEF received correctly.
REQ-037 frameReady pulsed in the same cycle a new frame 0x0123456 loads -> frameValid stays 1, dataOut=0x0123456, overrun=0.
REQ-038 SPI_RX_PARITY_EN defined, frame 0x0000003 with parity bit 1 -> parityError pulse, frameValid stays 0; with parity bit 0 -> frame accepted.
REQ-039 Reset asserted after 12 bits -> all outputs 0 immediately, no abortPulse, next frame received correctly.

Source files
------------

// File: rtl/spi_router_pkg.sv
// Shared definitions for the SPI receive path feeding the frame router.
package spi_router_pkg;

  localparam int DEFAULT_FRAME_SIZE = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } rxState_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with an optional
// registered rising-edge pulse taken from the synchronized level.
module spi_edge_sync #(
  parameter int STAGES      = 2,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic asyncIn,
  output logic syncOut,
  output logic risePulse
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else if (clear) begin
      chain <= '0;
    end else begin
      chain[0] <= asyncIn;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign syncOut = chain[STAGES-1];

  generate
    if (EDGE_DETECT) begin : gEdge
      logic delayed;

      // The pulse is registered so that the sampled data bit has settled by the time it is used.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          delayed   <= 1'b0;
          risePulse <= 1'b0;
        end else if (clear) begin
          delayed   <= 1'b0;
          risePulse <= 1'b0;
        end else begin
          delayed   <= syncOut;
          risePulse <= syncOut & ~delayed;
        end
      end
    end else begin : gNoEdge
      assign risePulse = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_rx_controller.sv
// SPI slave receiver: assembles size-bit frames (MSB first) from SCK/MOSI/CS and hands them on with valid/ready.
// Build macro SPI_RX_PARITY_EN adds a trailing even-parity bit per frame and the parityError pulse output.
//
// state   | meaning
// IDLE    | waiting for selector high; counter and shift register held at 0
// RECEIVE | shifting one MOSI bit per SCK rising edge
// DONE    | frame complete, SCK ignored until selector goes low
module spi_rx_controller
  import spi_router_pkg::*;
#(
  parameter int size        = DEFAULT_FRAME_SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            masterClock,
  input  logic            bitInMaster,
  input  logic            selector,
  input  logic            frameReady,
  output logic            frameValid,
  output logic [size-1:0] dataOut,
  output logic            overrun,
  output logic            abortPulse
`ifdef SPI_RX_PARITY_EN
  ,
  output logic            parityError
`endif
);

`ifdef SPI_RX_PARITY_EN
  localparam int FRAME_BITS = size + 1;
`else
  localparam int FRAME_BITS = size;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] DATA_COUNT = CNT_W'(size);

  rxState_t          state, nextState;
  logic [CNT_W-1:0]  bitCount;
  logic [size-1:0]   shiftReg;
  logic              sckRise, mosiSync, selSync;
  logic              unusedSckLevel, unusedMosiEdge, unusedSelEdge;
  logic              frameDone, sampleBit, abortNow, parityOk, frameGood;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) uSckSync (
    .clock(clock), .reset(reset), .clear(clear), .asyncIn(masterClock),
    .syncOut(unusedSckLevel), .risePulse(sckRise)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) uMosiSync (
    .clock(clock), .reset(reset), .clear(clear), .asyncIn(bitInMaster),
    .syncOut(mosiSync), .risePulse(unusedMosiEdge)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) uSelSync (
    .clock(clock), .reset(reset), .clear(clear), .asyncIn(selector),
    .syncOut(selSync), .risePulse(unusedSelEdge)
  );

  assign frameDone = (state == RECEIVE) && (bitCount == LAST_COUNT);
  assign sampleBit = (state == RECEIVE) && sckRise && !frameDone;
  assign abortNow  = (state == RECEIVE) && !selSync && !frameDone;
  assign frameGood = frameDone && parityOk;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (selSync) nextState = RECEIVE;
      RECEIVE: begin
        if (frameDone)     nextState = DONE;
        else if (!selSync) nextState = IDLE;
      end
      DONE:    if (!selSync) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= nextState;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitCount <= '0;
      shiftReg <= '0;
    end else if (clear || state == IDLE) begin
      bitCount <= '0;
      shiftReg <= '0;
    end else if (sampleBit) begin
      if (bitCount != DATA_COUNT) shiftReg <= {shiftReg[size-2:0], mosiSync};
      bitCount <= bitCount + CNT_W'(1);
    end
  end

`ifdef SPI_RX_PARITY_EN
  logic parityBit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      parityBit   <= 1'b0;
      parityError <= 1'b0;
    end else if (clear) begin
      parityBit   <= 1'b0;
      parityError <= 1'b0;
    end else begin
      if (state == IDLE)                               parityBit <= 1'b0;
      else if (sampleBit && bitCount == DATA_COUNT)    parityBit <= mosiSync;
      parityError <= frameDone && !parityOk;
    end
  end

  assign parityOk = ((^shiftReg) == parityBit);
`else
  assign parityOk = 1'b1;
`endif

  // A completing frame may load in the same cycle the router takes the old one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frameValid <= 1'b0;
      dataOut    <= '0;
      overrun    <= 1'b0;
      abortPulse <= 1'b0;
    end else if (clear) begin
      frameValid <= 1'b0;
      dataOut    <= '0;
      overrun    <= 1'b0;
      abortPulse <= 1'b0;
    end else begin
      abortPulse <= abortNow;
      if (frameGood && (!frameValid || frameReady)) begin
        dataOut    <= shiftReg;
        frameValid <= 1'b1;
      end else begin
        if (frameGood)  overrun    <= 1'b1;
        if (frameReady) frameValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_controller.sv
// Bench for spi_rx_controller: frame-level reference model scheduled from the SCK edges the bench drives,
// compared against the DUT on every falling clock edge, plus directed literal expectations.
module tb_spi_rx_controller;

  localparam int SIZE = 25;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 3;
`ifdef SPI_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b0, clear = 1'b0;
  logic masterClock = 1'b0, bitInMaster = 1'b0, selector = 1'b0, frameReady = 1'b0;
  logic frameValid, overrun, abortPulse;
  logic [SIZE-1:0] dataOut;
`ifdef SPI_RX_PARITY_EN
  logic parityError;
`endif

  spi_rx_controller #(.size(SIZE), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .masterClock(masterClock), .bitInMaster(bitInMaster), .selector(selector),
    .frameReady(frameReady), .frameValid(frameValid), .dataOut(dataOut),
    .overrun(overrun), .abortPulse(abortPulse)
`ifdef SPI_RX_PARITY_EN
    , .parityError(parityError)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  bit mValid = 0, mOverrun = 0, mAbort = 0, mParErr = 0;
  logic [SIZE-1:0] mData = '0, loadData = '0;
  int loadAt = -1, errAt = -1, abortAt = -1;
  bit checking = 0, randReady = 0;
  int finalRise = 0, validRiseCyc = 0, abortSeen = 0, parErrSeen = 0;
  logic prevValid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference model: frames complete a fixed latency after their last SCK rise, then follow valid/ready rules.
  always @(posedge clock) begin
    cyc++;
    if (!reset || clear) begin
      mValid = 0; mData = '0; mOverrun = 0; mAbort = 0; mParErr = 0;
    end else begin
      mAbort  = (cyc == abortAt);
      mParErr = (cyc == errAt);
      if (cyc == loadAt) begin
        if (!mValid || frameReady) begin
          mData  = loadData;
          mValid = 1;
        end else begin
          mOverrun = 1;
        end
      end else if (frameReady) begin
        mValid = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("frameValid", frameValid, mValid);
      chk("dataOut", dataOut, mData);
      chk("overrun", overrun, mOverrun);
      chk("abortPulse", abortPulse, mAbort);
`ifdef SPI_RX_PARITY_EN
      chk("parityError", parityError, mParErr);
      if (parityError) parErrSeen++;
`endif
      if (abortPulse) abortSeen++;
      if (frameValid && !prevValid) validRiseCyc = cyc;
      prevValid = frameValid;
    end
  end

  always @(negedge clock) if (randReady) frameReady = 1'($urandom_range(0, 1));

  // sched: 0 = partial frame, 1 = frame expected to load, 2 = frame expected to fail parity
  task automatic sendBits(input logic [31:0] bits, input int n, input int sched, input logic [SIZE-1:0] d);
    for (int i = n - 1; i >= 0; i--) begin
      bitInMaster = bits[i];
      repeat (4) @(negedge clock);
      masterClock = 1'b1;
      if (i == 0) begin
        finalRise = cyc;
        if (sched == 1) begin
          loadAt   = cyc + LAT;
          loadData = d;
        end else if (sched == 2) begin
          errAt = cyc + LAT;
        end
      end
      repeat (4) @(negedge clock);
      masterClock = 1'b0;
    end
  endtask

  task automatic txBits(input logic [SIZE-1:0] d, input bit badPar);
    logic p;
    p = (^d) ^ badPar;
    if (PARITY) sendBits({6'd0, d, p}, SIZE + 1, badPar ? 2 : 1, d);
    else        sendBits({7'd0, d}, SIZE, badPar ? 2 : 1, d);
  endtask

  task automatic startSel();
    selector = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic endSel(input bit aborted);
    repeat (3) @(negedge clock);
    selector = 1'b0;
    if (aborted) abortAt = cyc + SYNC + 1;
    repeat (10) @(negedge clock);
  endtask

  task automatic fullFrame(input logic [SIZE-1:0] d, input bit badPar);
    startSel();
    txBits(d, badPar);
    endSel(1'b0);
  endtask

  task automatic consume();
    frameReady = 1'b1;
    @(negedge clock);
    frameReady = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    repeat (3) @(negedge clock);
    chk("rstValid", frameValid, 0);
    chk("rstData", dataOut, 0);
    chk("rstOverrun", overrun, 0);
    chk("rstAbort", abortPulse, 0);
    reset = 1'b1;
    checking = 1;
    repeat (2) @(negedge clock);

    fullFrame(25'h1A5A5A5, 0);
    chk("latency", validRiseCyc - finalRise, LAT);
    chk("frame1Data", dataOut, 25'h1A5A5A5);
    chk("frame1Valid", frameValid, 1);
    consume();
    chk("consumedValid", frameValid, 0);

    fullFrame(25'h0000001, 0);
    fullFrame(25'h1FFFFFF, 0);
    chk("heldData", dataOut, 25'h0000001);
    chk("overrunSet", overrun, 1);
    chk("heldValid", frameValid, 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("clearOverrun", overrun, 0);
    chk("clearValid", frameValid, 0);
    chk("clearData", dataOut, 0);

    fullFrame(25'h0000005, 0);
    startSel();
    txBits(25'h0123456, 0);
    frameReady = 1'b1;
    @(negedge clock);
    frameReady = 1'b0;
    endSel(1'b0);
    chk("sameCycValid", frameValid, 1);
    chk("sameCycData", dataOut, 25'h0123456);
    chk("sameCycOverrun", overrun, 0);
    consume();

    abortSeen = 0;
    startSel();
    sendBits(32'h155, 10, 0, '0);
    endSel(1'b1);
    chk("abortCount", abortSeen, 1);
    chk("abortValid", frameValid, 0);
    fullFrame(25'h0ABCDEF, 0);
    chk("afterAbortData", dataOut, 25'h0ABCDEF);
    chk("afterAbortValid", frameValid, 1);

    abortSeen = 0;
    startSel();
    sendBits(32'hABC, 12, 0, '0);
    #2;
    reset = 1'b0;
    selector = 1'b0;
    #1;
    chk("midRstValid", frameValid, 0);
    chk("midRstData", dataOut, 0);
    chk("midRstOverrun", overrun, 0);
    chk("midRstAbort", abortPulse, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    fullFrame(25'h1234567, 0);
    chk("rstNoAbort", abortSeen, 0);
    chk("afterRstData", dataOut, 25'h1234567);
    consume();

`ifdef SPI_RX_PARITY_EN
    parErrSeen = 0;
    fullFrame(25'h0000003, 1);
    chk("parErrCount", parErrSeen, 1);
    chk("parErrValid", frameValid, 0);
    fullFrame(25'h0000003, 0);
    chk("parOkData", dataOut, 25'h0000003);
    chk("parOkValid", frameValid, 1);
    consume();
`endif

    randReady = 1;
    for (int k = 0; k < 10; k++) begin
      d = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        startSel();
        n = $urandom_range(1, SIZE - 1);
        sendBits(d, n, 0, '0);
        endSel(1'b1);
      end else begin
        fullFrame(d[SIZE-1:0], PARITY && ($urandom_range(0, 1) == 1));
      end
    end
    randReady = 0;
    frameReady = 1'b0;
    repeat (4) @(negedge clock);

    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
